gain_processor: RTL

Parametrised successor to the fixed ×2 sample processor in the audio path. It sits between the ADC interface and the DAC interface, after offset-binary input and before offset-binary output. Per sample it applies a programmable fixed-point gain, with mode select (pass, gain, mute, invert) and saturation. It includes its own data_valid edge detection and clip monitoring, so the external pulse generator is no longer needed.

---
 rtl/gain_processor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/gain_processor.sv
// Programmable-gain audio sample processor: offset-binary in, three-stage
// gain/mode/saturate pipeline, offset-binary out, with sticky clip monitoring.
module gain_processor #(
  parameter int DATA_W     = 10,
  parameter int GAIN_W     = 8,
  parameter int GAIN_FRAC  = 6,
  parameter int ADC_OFFSET = 512,
  parameter int DAC_OFFSET = 512,
  parameter int CNT_W      = 8
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic [GAIN_W-1:0] gain,
  input  logic [1:0]        mode,
  input  logic              clip_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              clip_flag,
  output logic [CNT_W-1:0]  clip_count
);

  localparam int PW = DATA_W + GAIN_W + 1;

  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_GAIN   = 2'b01;
  localparam logic [1:0] MODE_MUTE   = 2'b10;
  localparam logic [1:0] MODE_INVERT = 2'b11;

  localparam logic [DATA_W-1:0] ADC_OFF = DATA_W'(ADC_OFFSET);
  localparam logic [DATA_W-1:0] DAC_OFF = DATA_W'(DAC_OFFSET);
  localparam logic signed [PW-1:0] MAX_V = PW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PW-1:0] MIN_V = -(PW'(2 ** (DATA_W - 1)));

  logic                     r_dv_q;
  logic                     r_v1;
  logic signed [DATA_W-1:0] r_x;
  logic [GAIN_W-1:0]        r_gain;
  logic [1:0]               r_mode;
  logic                     r_v2;
  logic signed [PW-1:0]     r_r;

  logic                     w_start;
  logic [DATA_W-1:0]        w_x;
  logic signed [PW-1:0]     w_x_ext;
  logic signed [PW-1:0]     w_gain_ext;
  logic signed [PW-1:0]     w_prod;
  logic signed [DATA_W:0]   w_x_wide;
  logic signed [DATA_W:0]   w_neg;
  logic signed [PW-1:0]     w_r;
  logic                     w_hi;
  logic                     w_lo;
  logic                     w_clip;
  logic [DATA_W-1:0]        w_sat;

  // A level on data_valid yields one sample; r_dv_q resets high so a level
  // held through reset release is not mistaken for a fresh sample.
  assign w_start = data_valid & ~r_dv_q;
  assign w_x     = data_in - ADC_OFF;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv_q <= 1'b1;
      r_v1   <= 1'b0;
      r_x    <= '0;
      r_gain <= '0;
      r_mode <= MODE_PASS;
    end else begin
      r_dv_q <= data_valid;
      r_v1   <= w_start;
      if (w_start) begin
        r_x    <= $signed(w_x);
        r_gain <= gain;
        r_mode <= mode;
      end
    end
  end

  assign w_x_ext    = PW'(r_x);
  assign w_gain_ext = $signed({{(PW - GAIN_W){1'b0}}, r_gain});
  assign w_prod     = w_x_ext * w_gain_ext;
  assign w_x_wide   = (DATA_W + 1)'(r_x);
  assign w_neg      = -w_x_wide;

  always_comb begin
    w_r = '0;
    case (r_mode)
      MODE_PASS:   w_r = w_x_ext;
      MODE_GAIN:   w_r = w_prod >>> GAIN_FRAC;
      MODE_MUTE:   w_r = '0;
      MODE_INVERT: w_r = PW'(w_neg);
      default:     w_r = '0;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_r  <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_r <= w_r;
      end
    end
  end

  assign w_hi   = (r_r > MAX_V);
  assign w_lo   = (r_r < MIN_V);
  assign w_clip = r_v2 & (w_hi | w_lo);

  always_comb begin
    w_sat = DATA_W'(r_r);
    if (w_hi) begin
      w_sat = DATA_W'(MAX_V);
    end else if (w_lo) begin
      w_sat = DATA_W'(MIN_V);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= DAC_OFF;
      out_valid <= 1'b0;
    end else begin
      out_valid <= r_v2;
      if (r_v2) begin
        data_out <= w_sat + DAC_OFF;
      end
    end
  end

  // A clip completing on the same edge as a clear survives as a single event.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      clip_flag  <= 1'b0;
      clip_count <= '0;
    end else if (clip_clr) begin
      clip_flag  <= w_clip;
      clip_count <= w_clip ? CNT_W'(1) : '0;
    end else if (w_clip) begin
      clip_flag <= 1'b1;
      if (clip_count != {CNT_W{1'b1}}) begin
        clip_count <= clip_count + CNT_W'(1);
      end
    end
  end

endmodule
